// File: rtl/sparse_index_matcher.sv
// Merge-join of two index-sorted sparse streams: emits value pairs whose indices match,
// counts the matches per job and flags non-ascending indices.
module sparse_index_matcher #(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [IDX_W-1:0]  b_idx,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [IDX_W-1:0]  out_idx,
  output logic              done,
  output logic [IDX_W:0]    match_count,
  output logic              busy,
  output logic              order_err
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MERGE, S_DRAIN_A, S_DRAIN_B, S_FLUSH, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic                done_q, done_d, busy_q, busy_d;
  logic [CNT_W-1:0]    match_count_q, match_count_d;
  logic                order_err_q, order_err_d;
  logic [IDX_W-1:0]    last_a_q, last_a_d, last_b_q, last_b_d;
  logic                seen_a_q, seen_a_d, seen_b_q, seen_b_d;

  logic out_free, a_fire, b_fire;

  // Input handshakes; a pair is only taken when the output register can accept it
  always_comb begin
    out_free = !out_valid_q || out_ready;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    case (state_q)
      S_MERGE: begin
        if (a_valid && b_valid) begin
          if (a_idx < b_idx) begin
            a_ready = 1'b1;
          end else if (b_idx < a_idx) begin
            b_ready = 1'b1;
          end else if (out_free) begin
            a_ready = 1'b1;
            b_ready = 1'b1;
          end
        end
      end
      S_DRAIN_A: a_ready = a_valid;
      S_DRAIN_B: b_ready = b_valid;
      default: ;
    endcase
    a_fire = a_valid && a_ready;
    b_fire = b_valid && b_ready;
  end

  // Next-state, output register, counters and order tracking
  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q && !out_ready;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_idx_d     = out_idx_q;
    match_count_d = match_count_q;
    order_err_d   = order_err_q;
    last_a_d      = last_a_q;
    last_b_d      = last_b_q;
    seen_a_d      = seen_a_q;
    seen_b_d      = seen_b_q;

    if (a_fire) begin
      if (seen_a_q && (a_idx <= last_a_q)) order_err_d = 1'b1;
      last_a_d = a_idx;
      seen_a_d = 1'b1;
    end
    if (b_fire) begin
      if (seen_b_q && (b_idx <= last_b_q)) order_err_d = 1'b1;
      last_b_d = b_idx;
      seen_b_d = 1'b1;
    end
    // Both streams fire together only on an index match
    if (a_fire && b_fire) begin
      out_valid_d   = 1'b1;
      out_a_d       = a_data;
      out_b_d       = b_data;
      out_idx_d     = a_idx;
      match_count_d = match_count_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_MERGE;
          match_count_d = '0;
          order_err_d   = 1'b0;
          last_a_d      = '0;
          last_b_d      = '0;
          seen_a_d      = 1'b0;
          seen_b_d      = 1'b0;
        end
      end
      S_MERGE: begin
        if (a_fire && a_last && b_fire && b_last) state_d = S_FLUSH;
        else if (a_fire && a_last)                state_d = S_DRAIN_B;
        else if (b_fire && b_last)                state_d = S_DRAIN_A;
      end
      S_DRAIN_A: if (a_fire && a_last) state_d = S_FLUSH;
      S_DRAIN_B: if (b_fire && b_last) state_d = S_FLUSH;
      S_FLUSH:   if (out_free) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_idx_q     <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      match_count_q <= '0;
      order_err_q   <= 1'b0;
      last_a_q      <= '0;
      last_b_q      <= '0;
      seen_a_q      <= 1'b0;
      seen_b_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_idx_q     <= out_idx_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      match_count_q <= match_count_d;
      order_err_q   <= order_err_d;
      last_a_q      <= last_a_d;
      last_b_q      <= last_b_d;
      seen_a_q      <= seen_a_d;
      seen_b_q      <= seen_b_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_idx     = out_idx_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign match_count = match_count_q;
  assign order_err   = order_err_q;

endmodule

// File: doc/sparse_index_matcher.md
Name: sparse_index_matcher

Overview:
- Merge-join front end for the sparse dot-product datapath.
- Consumes two sparse vectors as (index, value) streams, each sorted by strictly ascending index, e.g. from comm-side buffers.
- Emits only the value pairs whose indices match, one pair per handshake, straight into the mult operands (dataa/datab).
- Signals completion with a match count, so the downstream accumulator knows how many products to sum.

Parameters:
- IDX_W, 8, index width in bits.
- DATA_W, 16, value width (half-precision float bits; passed through untouched).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a new match job; sampled only in IDLE.
- a_valid  in  1  vector A entry valid.
- a_ready  out  1  vector A entry accepted this cycle.
- a_idx  in  IDX_W  vector A index.
- a_data  in  DATA_W  vector A value.
- a_last  in  1  final entry of A.
- b_valid, b_ready, b_idx, b_data, b_last: same as the A ports, for vector B.
- out_valid  out  1  matched pair held.
- out_ready  in  1  downstream accepts the pair.
- out_a  out  DATA_W  value from A.
- out_b  out  DATA_W  value from B.
- out_idx  out  IDX_W  matched index.
- done  out  1  one-cycle pulse when the job completes.
- match_count  out  IDX_W+1  matches in the last job; held until the next start.
- busy  out  1  high in any state other than IDLE.
- order_err  out  1  sticky flag: a non-ascending index was seen; cleared on start.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - Outputs: out_valid=0, out_a=0, out_b=0, out_idx=0, done=0, match_count=0, busy=0, order_err=0.
  - Internal A/B last-index trackers and lastA/lastB flags cleared.
  - Reset mid-job discards the job; no done pulse.
- States: IDLE, MERGE, DRAIN_A, DRAIN_B, FLUSH, DONE.
- IDLE:
  - a_ready=b_ready=0.
  - start=1 clears match_count, order_err and the trackers, then goes to MERGE next cycle.
- MERGE (both heads must be valid before anything is consumed):
  - a_idx<b_idx: a_ready=1, consume A only.
  - b_idx<a_idx: b_ready=1, consume B only.
  - Equal indices: consume both only if the output register is free (out_valid=0, or out_valid&out_ready this cycle). Load out_a/out_b/out_idx and set out_valid next cycle; match_count+1.
  - Equal indices with the output register blocked: stall, neither ready asserted.
- a_ready and b_ready are combinational from state, valids, the index compare and output-register status. They never depend on out_valid toggling in the same cycle except through out_ready.
- Leaving MERGE:
  - A's last consumed first → DRAIN_B.
  - B's last consumed first → DRAIN_A.
  - Both lasts consumed in the same cycle → FLUSH.
- DRAIN_x: consume the remaining x entries at one per valid cycle, with no output, until x_last is accepted; then FLUSH.
- FLUSH: wait until out_valid=0 (pending pair accepted), then DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 only in IDLE.
- Output register holds its value stable while out_valid=1 and out_ready=0. A new pair may load in the same cycle the old one is accepted, giving full throughput of one match per cycle.
- Latency: a matched pair appears on out_* the cycle after both inputs handshake.
- order_err: set if an accepted index is <= the previous accepted index on the same stream. Processing continues regardless; the flag is sticky until start.
- Each vector carries at least one entry (upstream guarantees this).
- match_count cannot overflow: maximum 2^IDX_W matches fits in IDX_W+1 bits.
- start while busy is ignored.

Test Plan:
1. A={(1,a1),(3,a3),(7,a7)}, B={(3,b3),(7,b7),(9,b9)}, out_ready=1 → pairs (3,a3,b3), (7,a7,b7) on consecutive valid cycles; B's 9 drained; done pulse; match_count=2.
2. Disjoint A={0,2,4}, B={1,3,5} → out_valid never asserted; done; match_count=0.
3. Identical vectors with 4 entries, out_ready held 0 for 5 cycles after the first pair → first pair stable throughout, a_ready=b_ready=0 during the stall; after release, all 4 pairs emitted in order; match_count=4.
4. Both lasts accepted on the same matched index 5, with out_ready=0 → state holds in FLUSH; done asserts one cycle after the pair is accepted.
5. A indices {4,2} → order_err=1 at acceptance of 2; job completes; next start clears order_err.
6. Assert reset during MERGE with out_valid=1 → all outputs 0 immediately, no done; a following start runs case 1 correctly.
